// File: rtl/decimal_bcd_encoder.sv
// decimal_bcd_encoder
//   Synchronizes and debounces ten one-hot decimal lines (y0..y9) and emits
//   one BCD code per press on a valid/ready handshake. Multi-line presses
//   that settle produce a one-cycle err pulse instead of a code.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   y0..y9       asynchronous active-high decimal lines
//   a,b,c,d      BCD code, a = MSB (weight 8), d = LSB (weight 1)
//   valid/ready  output handshake; code held until accepted
//   err          one-cycle pulse on a debounced multi-line vector
module decimal_bcd_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic y0, y1, y2, y3, y4, y5, y6, y7, y8, y9,
  output logic a, b, c, d,
  output logic valid,
  input  logic ready,
  output logic err
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, WAIT_REL} state_t;

  localparam logic [8:0] DC = 9'(DEBOUNCE_CYCLES);

  state_t     state;
  logic [9:0] sync1, sync2, cand;
  logic [7:0] cnt;
  logic [3:0] code;
  logic [9:0] v;
  logic       v_zero, v_multi, resolve;
  logic [8:0] cnt_inc;

  assign v       = sync2;
  assign v_zero  = (v == 10'd0);
  // Clearing the lowest set bit leaves something only if >=2 bits were set.
  assign v_multi = ((v & (v - 10'd1)) != 10'd0);
  assign cnt_inc = {1'b0, cnt} + 9'd1;
  assign {a, b, c, d} = code;

  function automatic logic [3:0] enc(input logic [9:0] x);
    enc = 4'd0;
    for (int k = 0; k < 10; k++)
      if (x[k]) enc = 4'(k);
  endfunction

  // Resolve fires on the sample that brings the run length to DEBOUNCE_CYCLES;
  // when the threshold is 1 that is the very first nonzero sample in IDLE.
  always_comb begin
    resolve = 1'b0;
    case (state)
      IDLE:     resolve = !v_zero && (DC == 9'd1);
      DEBOUNCE: resolve = (v == cand) && (cnt_inc == DC);
      default:  resolve = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
      code  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      state <= IDLE;
    end else begin
      sync1 <= {y9, y8, y7, y6, y5, y4, y3, y2, y1, y0};
      sync2 <= sync1;
      err   <= 1'b0;
      if (resolve) begin
        cnt <= '0;
        if (v_multi) begin
          err   <= 1'b1;
          state <= WAIT_REL;
        end else begin
          code  <= enc(v);
          valid <= 1'b1;
          state <= HOLD;
        end
      end else begin
        case (state)
          IDLE: if (!v_zero) begin
            cand  <= v;
            cnt   <= 8'd1;
            state <= DEBOUNCE;
          end
          DEBOUNCE: begin
            if (v_zero) begin
              cnt   <= '0;
              state <= IDLE;
            end else if (v == cand) begin
              cnt <= cnt_inc[7:0];
            end else begin
              cand <= v;
              cnt  <= 8'd1;
            end
          end
          // Inputs are ignored here; the held code goes out exactly once.
          HOLD: if (ready) begin
            valid <= 1'b0;
            cnt   <= '0;
            state <= WAIT_REL;
          end
          WAIT_REL: begin
            if (!v_zero) begin
              cnt <= '0;
            end else if (cnt_inc == DC) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt_inc[7:0];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decimal_bcd_encoder.sv
module tb_decimal_bcd_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] keys = '0;
  logic       ready = 1'b0;
  logic       a, b, c, d, valid, err;

  int n_assert = 0;
  int n_fail   = 0;
  int errs_seen = 0;
  int errs_exp  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  decimal_bcd_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .y0(keys[0]), .y1(keys[1]), .y2(keys[2]), .y3(keys[3]), .y4(keys[4]),
    .y5(keys[5]), .y6(keys[6]), .y7(keys[7]), .y8(keys[8]), .y9(keys[9]),
    .a(a), .b(b), .c(c), .d(d),
    .valid(valid), .ready(ready), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every accepted code must be the next press the bench expects.
  always @(posedge clk) begin
    if (rst_n && err) errs_seen++;
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_code", {28'd0, a, b, c, d}, 32'hffff_ffff);
      end else begin
        chk("accepted_code", {28'd0, a, b, c, d}, 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int h, gap, k1, k2, wait_cnt;

    // Reset with a key already high: everything quiet.
    keys = 10'b1 << 5;
    ready = 1'b1;
    #12;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_code", {28'd0, a, b, c, d}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // First press latency: valid appears after edge 5, lasts one cycle.
    @(posedge clk); #1;
    exp_q.push_back(5);
    rst_n = 1'b1;
    tick(5);
    chk("lat_before_e5", {31'd0, valid}, 32'd0);
    tick(1);
    chk("lat_valid_e5", {31'd0, valid}, 32'd1);
    chk("lat_code_e5", {28'd0, a, b, c, d}, 32'd5);
    tick(1);
    chk("lat_onecycle", {31'd0, valid}, 32'd0);
    keys = '0;
    tick(10);

    // Sweep of all ten keys.
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(k);
      keys = 10'b1 << k;
      tick(10);
      keys = '0;
      tick(10);
    end
    chk("sweep_drained", 32'(exp_q.size()), 32'd0);
    chk("sweep_no_err", 32'(errs_seen), 32'd0);

    // Bouncing y7: nothing until it settles, then exactly one 7.
    for (int i = 0; i < 12; i++) begin
      keys = ((i % 4) < 2) ? (10'b1 << 7) : 10'd0;
      tick(1);
    end
    chk("bounce_no_code", {31'd0, valid}, 32'd0);
    exp_q.push_back(7);
    keys = 10'b1 << 7;
    tick(12);
    keys = '0;
    tick(12);
    chk("bounce_drained", 32'(exp_q.size()), 32'd0);

    // Two lines at once: one err pulse, no code; then y3 alone works.
    keys = (10'b1 << 3) | (10'b1 << 8);
    errs_exp = errs_seen + 1;
    tick(10);
    keys = '0;
    tick(10);
    chk("multi_err_once", 32'(errs_seen), 32'(errs_exp));
    exp_q.push_back(3);
    keys = 10'b1 << 3;
    tick(10);
    keys = '0;
    tick(10);
    chk("multi_then_single", 32'(exp_q.size()), 32'd0);

    // Backpressure: held through release and 20 idle cycles.
    ready = 1'b0;
    exp_q.push_back(9);
    keys = 10'b1 << 9;
    tick(8);
    keys = '0;
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid_held", {31'd0, valid}, 32'd1);
      chk("bp_code_held", {28'd0, a, b, c, d}, 32'd9);
      tick(1);
    end
    ready = 1'b1;
    tick(1);
    chk("bp_valid_dropped", {31'd0, valid}, 32'd0);
    tick(20);
    chk("bp_single_delivery", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while holding a code.
    ready = 1'b0;
    keys = 10'b1 << 4;
    tick(8);
    chk("hold4_valid", {31'd0, valid}, 32'd1);
    chk("hold4_code", {28'd0, a, b, c, d}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    chk("async_rst_code", {28'd0, a, b, c, d}, 32'd0);
    #2 rst_n = 1'b1;
    exp_q.push_back(4);
    ready = 1'b1;
    tick(10);
    keys = '0;
    tick(10);
    chk("rst_redebounce", 32'(exp_q.size()), 32'd0);

    // Random clean presses, occasional multi-line, random backpressure.
    errs_exp = errs_seen;
    for (int it = 0; it < 40; it++) begin
      k1 = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) begin
        k2 = (k1 + $urandom_range(1, 9)) % 10;
        keys = (10'b1 << k1) | (10'b1 << k2);
        errs_exp++;
      end else begin
        keys = 10'b1 << k1;
        exp_q.push_back(k1);
      end
      h = $urandom_range(5, 15);
      for (int i = 0; i < h; i++) begin
        ready = $urandom_range(0, 1) == 1;
        tick(1);
      end
      keys = '0;
      ready = 1'b1;
      wait_cnt = 0;
      while (valid && wait_cnt < 50) begin
        tick(1);
        wait_cnt++;
      end
      if (wait_cnt >= 50) chk("rand_accept_timeout", {31'd0, valid}, 32'd0);
      gap = $urandom_range(8, 14);
      tick(gap);
    end
    tick(5);
    chk("rand_all_delivered", 32'(exp_q.size()), 32'd0);
    chk("rand_err_count", 32'(errs_seen), 32'(errs_exp));
    chk("final_idle_valid", {31'd0, valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
